// File: rtl/div_seq.sv
// div_seq: sequential signed divider for the HD6309 DIVD and DIVQ instructions.
// Restoring shift-subtract, one quotient bit per clock. Results are sign-corrected
// in a dedicated cycle and then announced with a one-cycle done pulse.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   start_in     one-cycle request, accepted only when idle
//   sz_in        0 = DIVD (16/8), 1 = DIVQ (32/16), sampled with start_in
//   dividend_in  dividend (DIVD uses [15:0])
//   divisor_in   divisor (DIVD uses [7:0])
//   CCR          condition codes in, sampled with start_in
//   busy_out     high while an operation is in flight
//   done_out     one-cycle completion pulse
//   div0_out     divisor was zero, valid with done_out
//   quot_out     signed quotient (DIVD: [7:0], upper byte zero)
//   rem_out      signed remainder (DIVD: [7:0], upper byte zero)
//   CCRo         updated condition codes: C=0 V=1 Z=2 N=3, [7:4] passed through
module div_seq (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        sz_in,
    input  logic [31:0] dividend_in,
    input  logic [15:0] divisor_in,
    input  logic [7:0]  CCR,
    output logic        busy_out,
    output logic        done_out,
    output logic        div0_out,
    output logic [15:0] quot_out,
    output logic [15:0] rem_out,
    output logic [7:0]  CCRo
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      state;
    logic        sz;
    logic [7:0]  ccr_l;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_sh;    // dividend magnitude shifting out, quotient bits shifting in
    logic [15:0] dvs_mag;
    logic [15:0] prem;      // partial remainder
    logic [4:0]  cnt;

    // Operand sign extension and magnitude. Magnitudes are kept unsigned, so the
    // most-negative operand maps onto 2^(w-1) without needing an extra bit.
    logic [31:0] dvd_ext;
    logic [31:0] dvd_abs;
    logic [15:0] dvs_ext;
    logic [15:0] dvs_abs;

    always_comb begin
        dvd_ext = sz_in ? dividend_in : {{16{dividend_in[15]}}, dividend_in[15:0]};
        dvs_ext = sz_in ? divisor_in  : {{8{divisor_in[7]}}, divisor_in[7:0]};
        dvd_abs = dvd_ext[31] ? (~dvd_ext + 32'd1) : dvd_ext;
        dvs_abs = dvs_ext[15] ? (~dvs_ext + 16'd1) : dvs_ext;
    end

    // Trial subtract, one bit wider than the divisor. prem < divisor <= 2^15,
    // so the shifted value fits in 16 bits and trial[16] is the true sign.
    logic [16:0] shifted;
    logic [16:0] trial;

    always_comb begin
        shifted = {prem, dvd_sh[31]};
        trial   = shifted - {1'b0, dvs_mag};
    end

    // Sign correction and overflow: the quotient is extended to 34 bits so the
    // range test is a simple "upper bits all equal" check.
    logic [33:0] q_ext;
    logic [33:0] q_sgn;
    logic [15:0] r_sgn;
    logic [15:0] q_trunc;
    logic [15:0] r_trunc;
    logic        ovf;
    logic        n_flag;

    always_comb begin
        q_ext   = sz ? {2'b00, dvd_sh} : {18'h0, dvd_sh[15:0]};
        q_sgn   = (dvd_neg ^ dvs_neg) ? (~q_ext + 34'd1) : q_ext;
        r_sgn   = dvd_neg ? (~prem + 16'd1) : prem;
        ovf     = sz ? ~((&q_sgn[33:15]) | ~(|q_sgn[33:15]))
                     : ~((&q_sgn[33:7])  | ~(|q_sgn[33:7]));
        q_trunc = sz ? q_sgn[15:0] : {8'h00, q_sgn[7:0]};
        r_trunc = sz ? r_sgn       : {8'h00, r_sgn[7:0]};
        n_flag  = sz ? q_sgn[15]   : q_sgn[7];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            sz       <= 1'b0;
            ccr_l    <= '0;
            dvd_neg  <= 1'b0;
            dvs_neg  <= 1'b0;
            dvd_sh   <= '0;
            dvs_mag  <= '0;
            prem     <= '0;
            cnt      <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            div0_out <= 1'b0;
            quot_out <= '0;
            rem_out  <= '0;
            CCRo     <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        sz       <= sz_in;
                        ccr_l    <= CCR;
                        dvd_neg  <= dvd_ext[31];
                        dvs_neg  <= dvs_ext[15];
                        // DIVD magnitude sits in the top half so the MSB shifts out first
                        dvd_sh   <= sz_in ? dvd_abs : {dvd_abs[15:0], 16'h0000};
                        dvs_mag  <= dvs_abs;
                        prem     <= '0;
                        cnt      <= sz_in ? 5'd31 : 5'd15;
                        busy_out <= 1'b1;
                        div0_out <= (dvs_ext == '0);
                        state    <= (dvs_ext == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    dvd_sh <= {dvd_sh[30:0], ~trial[16]};
                    prem   <= trial[16] ? shifted[15:0] : trial[15:0];
                    if (cnt == 5'd0) begin
                        state <= SIGN;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                SIGN: begin
                    quot_out <= q_trunc;
                    rem_out  <= r_trunc;
                    CCRo     <= {ccr_l[7:4], n_flag, (q_trunc == '0), ovf, q_trunc[0]};
                    state    <= DONE;
                end
                DONE: begin
                    // divide by zero leaves quotient/remainder alone and passes CCR through
                    if (div0_out) begin
                        CCRo <= ccr_l;
                    end
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        start_in = 1'b0;
    logic        sz_in = 1'b0;
    logic [31:0] dividend_in = '0;
    logic [15:0] divisor_in = '0;
    logic [7:0]  CCR = '0;
    logic        busy_out;
    logic        done_out;
    logic        div0_out;
    logic [15:0] quot_out;
    logic [15:0] rem_out;
    logic [7:0]  CCRo;

    int total = 0;
    int bad = 0;
    int vec_id = 0;

    div_seq dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .start_in    (start_in),
        .sz_in       (sz_in),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .CCR         (CCR),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .div0_out    (div0_out),
        .quot_out    (quot_out),
        .rem_out     (rem_out),
        .CCRo        (CCRo)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain signed integer division (truncating), then the result
    // width limits and flag rules applied to the truncated quotient.
    task automatic model_op(input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                            input logic [7:0] cc_in, input logic [15:0] pq, input logic [15:0] pr,
                            output logic [15:0] q, output logic [15:0] r,
                            output logic [7:0] cc, output logic d0);
        longint a, b, qq, rr, lo, hi;
        logic   ovf;
        if (s) begin
            a = longint'($signed(dvd));
            b = longint'($signed(dvs));
            lo = -32768;
            hi = 32767;
        end else begin
            a = longint'($signed(dvd[15:0]));
            b = longint'($signed(dvs[7:0]));
            lo = -128;
            hi = 127;
        end
        if (b == 0) begin
            d0 = 1'b1;
            q  = pq;
            r  = pr;
            cc = cc_in;
        end else begin
            d0  = 1'b0;
            qq  = a / b;
            rr  = a % b;
            ovf = (qq < lo) || (qq > hi);
            q   = s ? qq[15:0] : {8'h00, qq[7:0]};
            r   = s ? rr[15:0] : {8'h00, rr[7:0]};
            cc  = {cc_in[7:4], (s ? q[15] : q[7]), (q == 16'h0000), ovf, q[0]};
        end
    endtask

    // Model state: what the outputs must be after each rising edge.
    logic        m_active = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic [7:0]  m_cc = '0, p_cc = '0;
    logic        m_d0 = 1'b0, p_d0 = 1'b0;

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) begin
                m_active = 1'b0;
                m_busy   = 1'b0;
                m_done   = 1'b0;
                m_q      = '0;
                m_r      = '0;
                m_cc     = '0;
                m_d0     = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_active) begin
                    m_k++;
                    if (m_k == m_lat) begin
                        m_active = 1'b0;
                        m_busy   = 1'b0;
                        m_done   = 1'b1;
                        m_q      = p_q;
                        m_r      = p_r;
                        m_cc     = p_cc;
                        m_d0     = p_d0;
                    end
                end else if (start_in) begin
                    model_op(sz_in, dividend_in, divisor_in, CCR, m_q, m_r, p_q, p_r, p_cc, p_d0);
                    m_lat    = p_d0 ? 1 : (sz_in ? 34 : 18);
                    m_k      = 0;
                    m_active = 1'b1;
                    m_busy   = 1'b1;
                end
            end
        end
    end

    // Compare process: handshake every cycle, results whenever no operation is in flight.
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            check("rst_busy", 32'(busy_out), 32'd0);
            check("rst_done", 32'(done_out), 32'd0);
            check("rst_div0", 32'(div0_out), 32'd0);
            check("rst_quot", 32'(quot_out), 32'd0);
            check("rst_rem",  32'(rem_out),  32'd0);
            check("rst_ccro", 32'(CCRo),     32'd0);
        end else begin
            check("busy", 32'(busy_out), 32'(m_busy));
            check("done", 32'(done_out), 32'(m_done));
            if (!m_active) begin
                check("quot", 32'(quot_out), 32'(m_q));
                check("rem",  32'(rem_out),  32'(m_r));
                check("ccro", 32'(CCRo),     32'(m_cc));
                check("div0", 32'(div0_out), 32'(m_d0));
            end
        end
    end

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [7:0] cc);
        sz_in       = s;
        dividend_in = dvd;
        divisor_in  = dvs;
        CCR         = cc;
        start_in    = 1'b1;
        @(negedge clk_in);
        start_in    = 1'b0;
    endtask

    // Counts rising edges after the start edge until done_out; optionally
    // throws stray start pulses at the busy block.
    task automatic wait_done(input logic noise, output int lat);
        lat = 0;
        while (!done_out && lat < 100) begin
            @(negedge clk_in);
            lat++;
            start_in = noise && ($urandom_range(0, 7) == 0);
            if (start_in) begin
                sz_in       = 1'($urandom_range(0, 1));
                dividend_in = $urandom;
                divisor_in  = 16'($urandom_range(0, 65535));
                CCR         = 8'($urandom_range(0, 255));
            end
        end
        start_in = 1'b0;
        if (!done_out) check("done_wait", 32'(done_out), 32'd1);
    endtask

    task automatic run_dir(input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                           input logic [7:0] cc, input int elat, input logic [15:0] eq,
                           input logic [15:0] er, input logic [7:0] ecc, input logic ed0);
        int lat;
        vec_id++;
        issue(s, dvd, dvs, cc);
        wait_done(1'b0, lat);
        check($sformatf("v%0d_lat",  vec_id), 32'(lat), 32'(elat));
        check($sformatf("v%0d_quot", vec_id), 32'(quot_out), 32'(eq));
        check($sformatf("v%0d_rem",  vec_id), 32'(rem_out),  32'(er));
        check($sformatf("v%0d_ccro", vec_id), 32'(CCRo),     32'(ecc));
        check($sformatf("v%0d_div0", vec_id), 32'(div0_out), 32'(ed0));
    endtask

    initial begin
        logic [15:0] tq, tr;
        logic [7:0]  tcc;
        logic        td0;
        int          dcount;

        // Pin the reference model to hand-computed values.
        model_op(1'b0, 32'h0000_FF9C, 16'h0007, 8'h00, 16'h0, 16'h0, tq, tr, tcc, td0);
        check("model_q_neg", 32'(tq), 32'h00F2);
        check("model_r_neg", 32'(tr), 32'h00FE);
        model_op(1'b0, 32'h0000_7FFF, 16'h0001, 8'h00, 16'h0, 16'h0, tq, tr, tcc, td0);
        check("model_ovf_cc", 32'(tcc), 32'h0B);
        model_op(1'b1, 32'd1000000, 16'd1000, 8'h00, 16'h0, 16'h0, tq, tr, tcc, td0);
        check("model_divq", 32'(tq), 32'h03E8);

        #1 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b1;
        @(negedge clk_in);

        //       sz    dividend       divisor  CCR    lat quot     rem      CCRo   div0
        run_dir(1'b0, 32'd100,       16'd7,    8'hA0, 18, 16'h000E, 16'h0002, 8'hA0, 1'b0);
        run_dir(1'b0, 32'h0000_FF9C, 16'h0007, 8'h00, 18, 16'h00F2, 16'h00FE, 8'h08, 1'b0);
        run_dir(1'b0, 32'h0000_0064, 16'h00F9, 8'h00, 18, 16'h00F2, 16'h0002, 8'h08, 1'b0);
        run_dir(1'b0, 32'h0000_7FFF, 16'h0001, 8'h00, 18, 16'h00FF, 16'h0000, 8'h0B, 1'b0);
        run_dir(1'b1, 32'd1000000,   16'd1000, 8'h20, 34, 16'h03E8, 16'h0000, 8'h20, 1'b0);
        // divisor low byte zero is a DIVD divide-by-zero; results hold
        run_dir(1'b0, 32'h0000_1234, 16'h0100, 8'hD5, 1,  16'h03E8, 16'h0000, 8'hD5, 1'b1);
        run_dir(1'b1, 32'h1234_5678, 16'h0000, 8'hD5, 1,  16'h03E8, 16'h0000, 8'hD5, 1'b1);
        run_dir(1'b0, 32'h0000_8000, 16'h00FF, 8'h00, 18, 16'h0000, 16'h0000, 8'h06, 1'b0);
        run_dir(1'b0, 32'h0000_FF80, 16'h0001, 8'h00, 18, 16'h0080, 16'h0000, 8'h08, 1'b0);
        run_dir(1'b1, 32'h8000_0000, 16'h8000, 8'h00, 34, 16'h0000, 16'h0000, 8'h06, 1'b0);
        run_dir(1'b1, 32'h8000_0000, 16'h0003, 8'hF0, 34, 16'h5556, 16'hFFFE, 8'hF2, 1'b0);
        run_dir(1'b1, 32'hFFFF_FF85, 16'h000A, 8'h00, 34, 16'hFFF4, 16'hFFFD, 8'h08, 1'b0);
        run_dir(1'b0, 32'h0000_0005, 16'h0007, 8'h00, 18, 16'h0000, 16'h0005, 8'h04, 1'b0);

        // Stray start while busy, then reset in the middle of CALC.
        run_dir(1'b0, 32'd200,       16'd7,    8'h00, 18, 16'h001C, 16'h0004, 8'h00, 1'b0);
        issue(1'b0, 32'd100, 16'd7, 8'h00);
        @(negedge clk_in);
        sz_in = 1'b1; dividend_in = 32'd1000; divisor_in = 16'd0; start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_quot", 32'(quot_out), 32'd0);
        check("abort_rem",  32'(rem_out),  32'd0);
        dcount = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (done_out) dcount++;
        end
        check("abort_nodone", 32'(dcount), 32'd0);
        #2 rst_n_in = 1'b1;
        @(negedge clk_in);
        run_dir(1'b0, 32'd100,       16'd7,    8'h00, 18, 16'h000E, 16'h0002, 8'h00, 1'b0);

        // Randomized operations, back-to-back or with short gaps, stray starts while busy.
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] dvd;
            logic [15:0] dvs;
            int          mode;
            int          lat;
            int          elat;
            s    = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 7));
            dvd  = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) dvd = -dvd;
            dvs  = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 14);
            if (mode == 0) dvs = s ? 16'h0000 : {8'($urandom_range(0, 255)), 8'h00};
            if (mode == 1) dvd = s ? 32'h8000_0000 : 32'h0000_8000;
            if (mode == 2) dvs = s ? 16'h8000 : 16'h0080;
            if (mode == 3) dvs = 16'hFFFF;
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            issue(s, dvd, dvs, 8'($urandom_range(0, 255)));
            wait_done(1'b1, lat);
            elat = (s ? (dvs == 16'h0) : (dvs[7:0] == 8'h00)) ? 1 : (s ? 34 : 18);
            check("rand_lat", 32'(lat), 32'(elat));
        end

        repeat (3) @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
